pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised program-counter generator for the fetch stage. Successor to the plain PC
//  register: holds the fetch PC and issues req/ack fetch requests to instruction SRAM.
//  Arbitrates exception, ERET and branch redirects. Remembers a branch that arrives during
//  stall or wait-for-ack, and flags misaligned PCs (AdEL).
// PARAMETERS
//  WIDTH      32            PC / address width in bits
//  RESET_VEC  32'hbfc0_0000 PC value loaded on reset
//  EXC_VEC    32'hbfc0_0380 exception entry PC
//  INC        4             sequential PC increment (bytes)
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      reset, asynchronous, active-high
//  stall_i        in   1      pipeline stall; PC must not advance
//  excpt_i        in   1      exception redirect to EXC_VEC (highest priority)
//  eret_i         in   1      ERET redirect to epc_i
//  epc_i          in   WIDTH  ERET return address
//  branch_i       in   1      taken branch/jump; next sequential PC replaced by target
//  branch_tgt_i   in   WIDTH  branch/jump target
//  inst_req_o     out  1      fetch request, held until inst_ack_i
//  inst_addr_o    out  WIDTH  fetch address (= pc_o)
//  inst_ack_i     in   1      SRAM accepted/returned fetch at inst_addr_o
//  pc_o           out  WIDTH  current fetch PC
//  fetch_done_o   out  1      1-cycle pulse: fetch of pc_o completed and consumed
//  adel_o         out  1      pc_o[1:0] != 0 (instruction address error)
// BEHAVIOUR
//  Reset (async): pc_o=RESET_VEC, state=BOOT, pend_valid=0, pend_addr=0, inst_req_o=0,
//   fetch_done_o=0, adel_o=0.
//  FSM: BOOT -> RUN after one clk (first request in 2nd cycle after reset release).
//   RUN -> HALT when adel_o=1 (no request issued). HALT -> RUN only on excpt_i/eret_i.
//  inst_req_o = (state==RUN) & !adel_o. inst_addr_o = pc_o, held stable while req & !ack.
//  adv = inst_req_o & inst_ack_i & !stall_i. fetch_done_o = adv & !excpt_i & !eret_i.
//  Next-PC priority, evaluated each cycle:
//   1 excpt_i: pc<=EXC_VEC; pend_valid<=0; state<=RUN. Ignores stall_i and ack.
//   2 eret_i (no excpt_i): pc<=epc_i; pend_valid<=0; state<=RUN. Ignores stall_i and ack.
//   3 adv & branch_i: pc<=branch_tgt_i; pend_valid<=0.
//   4 adv & pend_valid: pc<=pend_addr; pend_valid<=0.
//   5 adv: pc<=pc+INC (mod 2^WIDTH; wraps from all-ones).
//   6 !adv & branch_i: pend_addr<=branch_tgt_i; pend_valid<=1; pc unchanged.
//     A later branch overwrites an earlier pending one.
//   7 otherwise hold.
//  ack with stall_i=1: no advance; SRAM re-presents the same address next cycle
//   (request stays high).
//  ack on the same cycle as excpt_i/eret_i: fetched word is discarded (no fetch_done_o).
//  adel_o is a registered copy of the low 2 bits of the new pc (nonzero -> 1).
//   It changes with pc and is combinational in pc_o[1:0] only.
//  Reset mid-operation: all state returns to reset values immediately;
//   a pending branch is lost.
// TESTING
//  T1 rst 1->0, ack tied 1, no stall -> pc_o bfc00000 (2 cycles), bfc00004, bfc00008;
//     req first high cycle 2.
//  T2 pc=bfc00010, ack=1, stall_i=1 for 3 cycles -> pc holds bfc00010, fetch_done_o=0;
//     stall drop -> bfc00014.
//  T3 ack=0, branch_i pulse tgt=bfc00100 -> pc holds; next ack -> pc=bfc00100
//     (not +4); pend cleared.
//  T4 excpt_i & eret_i & branch_i same cycle, stall_i=1 -> pc=bfc00380; no pending
//     branch applied afterwards.
//  T5 eret_i epc_i=bfc00102 -> adel_o=1, inst_req_o=0, state HALT;
//     excpt_i -> pc=bfc00380, req resumes.
//  T6 assert rst mid-fetch with pending branch -> pc=bfc00000 asynchronously;
//     after release sequence restarts as T1.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator. It holds the fetch PC, runs the req/ack handshake to
// instruction SRAM, arbitrates redirects and keeps a branch that arrives while no fetch advances.
module pc_gen #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'hbfc0_0000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'hbfc0_0380,
    parameter int unsigned      INC       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             excpt_i,
    input  logic             eret_i,
    input  logic [WIDTH-1:0] epc_i,
    input  logic             branch_i,
    input  logic [WIDTH-1:0] branch_tgt_i,
    output logic             inst_req_o,
    output logic [WIDTH-1:0] inst_addr_o,
    input  logic             inst_ack_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             fetch_done_o,
    output logic             adel_o
);

    typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic             pend_valid_q, pend_valid_d;
    logic             adv;

    // adel tracks the registered PC, so it is effectively a registered copy of the new PC bits.
    assign adel_o       = |pc_q[1:0];
    assign pc_o         = pc_q;
    assign inst_addr_o  = pc_q;
    assign inst_req_o   = (state_q == StRun) && !adel_o;
    assign adv          = inst_req_o && inst_ack_i && !stall_i;
    assign fetch_done_o = adv && !excpt_i && !eret_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_addr_d  = pend_addr_q;
        pend_valid_d = pend_valid_q;

        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (adel_o) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase

        if (excpt_i) begin
            pc_d         = EXC_VEC;
            pend_valid_d = 1'b0;
            state_d      = StRun;
        end else if (eret_i) begin
            pc_d         = epc_i;
            pend_valid_d = 1'b0;
            state_d      = StRun;
        end else if (adv) begin
            if (branch_i) begin
                pc_d = branch_tgt_i;
            end else if (pend_valid_q) begin
                pc_d = pend_addr_q;
            end else begin
                pc_d = pc_q + WIDTH'(INC);
            end
            pend_valid_d = 1'b0;
        end else if (branch_i) begin
            // Branch seen while the fetch is not consumed; newest target wins.
            pend_addr_d  = branch_tgt_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StBoot;
            pc_q         <= RESET_VEC;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule
